vga_pmod_out: RTL and testbench

// Output stage directly downstream of the quine text renderer. Takes its registered

---
 rtl/vga_pkg.sv | 27 ++
 rtl/sync_period_meter.sv | 51 +++++
 rtl/vga_pmod_out.sv | 142 ++++++++++++++
 tb/tb_vga_pmod_out.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA PMOD output stage: timing defaults, PMOD bit map, lock states.
package vga_pkg;

  localparam int unsigned H_TOTAL_DEF     = 800;
  localparam int unsigned V_TOTAL_DEF     = 525;
  localparam int unsigned LOCK_FRAMES_DEF = 2;
  localparam int unsigned FG_SHIFT_DEF    = 6;
  localparam int unsigned PIX_DELAY_DEF   = 1;
  localparam int unsigned METER_W         = 10;

  // TinyVGA PMOD byte: {hsync,B0,G0,R0,vsync,B1,G1,R1}
  localparam int unsigned PMOD_HSYNC = 7;
  localparam int unsigned PMOD_B0    = 6;
  localparam int unsigned PMOD_G0    = 5;
  localparam int unsigned PMOD_R0    = 4;
  localparam int unsigned PMOD_VSYNC = 3;
  localparam int unsigned PMOD_B1    = 2;
  localparam int unsigned PMOD_G1    = 1;
  localparam int unsigned PMOD_R1    = 0;

  typedef enum logic [1:0] {
    SEARCH,
    CHECK,
    LOCKED
  } lock_state_t;

endpackage

// File: rtl/sync_period_meter.sv
// Measures ticks between falling edges of an active-low sync and flags whether each
// period equals TOTAL. The first falling edge only arms the meter.
module sync_period_meter import vga_pkg::*; #(
  parameter int unsigned TOTAL = H_TOTAL_DEF,
  parameter int unsigned CNT_W = METER_W
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_in,
  input  logic tick,
  output logic fall_c,
  output logic event_c,
  output logic ok_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             prev;
  logic             armed;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc_c;

  // A tick coincident with the edge belongs to the period that edge closes
  always_comb begin
    count_inc_c = count;
    if (tick && (count != CNT_MAX)) begin
      count_inc_c = count + CNT_W'(1);
    end
  end

  assign fall_c  = prev & ~sync_in;
  assign event_c = fall_c & armed;
  assign ok_c    = event_c & (count_inc_c == CNT_W'(TOTAL));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev  <= 1'b1;
      armed <= 1'b0;
      count <= '0;
    end else begin
      prev <= sync_in;
      if (fall_c) begin
        armed <= 1'b1;
        count <= '0;
      end else begin
        count <= count_inc_c;
      end
    end
  end

endmodule

// File: rtl/vga_pmod_out.sv
// Output stage after the text renderer: realigns pixel to syncs, checks 800x525 timing
// with a lock FSM, and drives the TinyVGA PMOD byte with a frame-cycled foreground.
module vga_pmod_out import vga_pkg::*; #(
  parameter int unsigned H_TOTAL     = H_TOTAL_DEF,
  parameter int unsigned V_TOTAL     = V_TOTAL_DEF,
  parameter int unsigned LOCK_FRAMES = LOCK_FRAMES_DEF,
  parameter int unsigned FG_SHIFT    = FG_SHIFT_DEF,
  parameter int unsigned PIX_DELAY   = PIX_DELAY_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       pixel_in,
  output logic [7:0] uo_out,
  output logic       locked,
  output logic [7:0] frame_count
);

  localparam int unsigned         GOOD_W    = $clog2(LOCK_FRAMES + 1);
  localparam logic [GOOD_W-1:0]   GOOD_LAST = GOOD_W'(LOCK_FRAMES - 1);

  logic h_fall_c, h_event_c, h_ok_c;
  logic v_fall_c, v_event_c, v_ok_c;

  lock_state_t       state, state_next;
  logic [GOOD_W-1:0] good, good_next;
  logic [2:0]        fg;
  logic [PIX_DELAY-1:0] pix_pipe;
  logic [PIX_DELAY:0]   pix_shift_c;
  logic [2:0]        colour_c;
  logic [7:0]        uo_next_c;
  logic              bad_c;

  sync_period_meter #(.TOTAL(H_TOTAL), .CNT_W(METER_W)) u_h_meter (
    .clk     (clk),
    .rst     (rst),
    .sync_in (hsync_in),
    .tick    (1'b1),
    .fall_c  (h_fall_c),
    .event_c (h_event_c),
    .ok_c    (h_ok_c)
  );

  // Vertical period is measured in hsync falling edges
  sync_period_meter #(.TOTAL(V_TOTAL), .CNT_W(METER_W)) u_v_meter (
    .clk     (clk),
    .rst     (rst),
    .sync_in (vsync_in),
    .tick    (h_fall_c),
    .fall_c  (v_fall_c),
    .event_c (v_event_c),
    .ok_c    (v_ok_c)
  );

  assign bad_c = (h_event_c & ~h_ok_c) | (v_event_c & ~v_ok_c);

  // Lock FSM: a bad line or frame always clears the good-frame streak
  always_comb begin
    state_next = state;
    good_next  = good;
    case (state)
      SEARCH: begin
        if (v_fall_c) begin
          state_next = CHECK;
          good_next  = '0;
        end
      end
      CHECK: begin
        if (bad_c) begin
          good_next = '0;
        end else if (v_event_c) begin
          good_next = good + GOOD_W'(1);
          if (good == GOOD_LAST) begin
            state_next = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (bad_c) begin
          state_next = CHECK;
          good_next  = '0;
        end
      end
      default: begin
        state_next = SEARCH;
        good_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= SEARCH;
      good   <= '0;
      locked <= 1'b0;
    end else begin
      state  <= state_next;
      good   <= good_next;
      locked <= (state_next == LOCKED);
    end
  end

  // Foreground index walks 1..7, stepping each 2**FG_SHIFT frames
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_count <= 8'd0;
      fg          <= 3'd1;
    end else if (v_fall_c) begin
      frame_count <= frame_count + 8'd1;
      if (&frame_count[FG_SHIFT-1:0]) begin
        fg <= (fg == 3'd7) ? 3'd1 : fg + 3'd1;
      end
    end
  end

  assign pix_shift_c = {pix_pipe, pixel_in};

  always_comb begin
    colour_c  = (pix_shift_c[PIX_DELAY] && locked) ? fg : 3'd0;
    uo_next_c = '0;
    uo_next_c[PMOD_HSYNC] = hsync_in;
    uo_next_c[PMOD_VSYNC] = vsync_in;
    uo_next_c[PMOD_R0]    = colour_c[0];
    uo_next_c[PMOD_R1]    = colour_c[0];
    uo_next_c[PMOD_G0]    = colour_c[1];
    uo_next_c[PMOD_G1]    = colour_c[1];
    uo_next_c[PMOD_B0]    = colour_c[2];
    uo_next_c[PMOD_B1]    = colour_c[2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_pipe <= '0;
      uo_out   <= 8'h88;
    end else begin
      pix_pipe <= pix_shift_c[PIX_DELAY-1:0];
      uo_out   <= uo_next_c;
    end
  end

endmodule

// File: tb/tb_vga_pmod_out.sv
// Self-checking bench for vga_pmod_out on a shrunken raster (10x6) so hundreds of frames fit.
module tb_vga_pmod_out;

  localparam int unsigned H_T   = 10;
  localparam int unsigned V_T   = 6;
  localparam int unsigned LOCK  = 2;
  localparam int unsigned FG_SH = 6;
  localparam int unsigned PIX_D = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       hsync_in, vsync_in, pixel_in;
  logic [7:0] uo_out;
  logic       locked;
  logic [7:0] frame_count;

  int n_tests = 0;
  int n_fail  = 0;

  vga_pmod_out #(
    .H_TOTAL(H_T), .V_TOTAL(V_T), .LOCK_FRAMES(LOCK), .FG_SHIFT(FG_SH), .PIX_DELAY(PIX_D)
  ) dut (
    .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in), .pixel_in(pixel_in),
    .uo_out(uo_out), .locked(locked), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Reference model: periods measured as time differences, lock as a good-frame streak
  bit         m_prev_hs, m_prev_vs, m_pix_d, m_locked;
  bit         m_h_armed, m_v_armed, m_started;
  int         m_t, m_h_last, m_lines, m_streak, m_frames;
  logic [7:0] m_uo;
  bit         lock_hist[$];

  typedef struct {
    logic       hs;
    logic       vs;
    logic       pix;
    logic [7:0] uo;
    logic       lk;
    logic [7:0] fc;
  } vec_t;
  vec_t vecs[7];

  function automatic logic [2:0] m_fg();
    return 3'(1 + ((m_frames >> FG_SH) % 7));
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %02h expected %02h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_prev_hs = 1; m_prev_vs = 1; m_pix_d = 0; m_locked = 0;
    m_h_armed = 0; m_v_armed = 0; m_started = 0;
    m_t = 0; m_h_last = 0; m_lines = 0; m_streak = 0; m_frames = 0;
    m_uo = 8'h88;
    lock_hist.delete();
  endtask

  task automatic step(input bit hs, input bit vs, input bit pix);
    logic [2:0] col;
    bit hf, vf, line_bad, frame_evt, frame_ok;
    hsync_in = hs; vsync_in = vs; pixel_in = pix;
    col  = (m_pix_d && m_locked) ? m_fg() : 3'd0;
    m_uo = {hs, col, vs, col};
    m_pix_d = pix;
    hf = m_prev_hs && !hs;
    vf = m_prev_vs && !vs;
    m_prev_hs = hs; m_prev_vs = vs;
    line_bad = 0; frame_evt = 0; frame_ok = 0;
    if (hf) begin
      if (m_h_armed && (m_t - m_h_last) != int'(H_T)) line_bad = 1;
      m_h_armed = 1;
      m_h_last  = m_t;
      m_lines++;
    end
    if (vf) begin
      if (m_v_armed) begin
        frame_evt = 1;
        frame_ok  = (m_lines == int'(V_T));
      end
      m_v_armed = 1;
      m_lines   = 0;
      m_frames++;
    end
    if (!m_started) begin
      if (vf) begin m_started = 1; m_streak = 0; end
    end else if (line_bad || (frame_evt && !frame_ok)) begin
      m_streak = 0;
    end else if (frame_evt) begin
      m_streak++;
    end
    m_locked = m_started && (m_streak >= int'(LOCK));
    m_t++;
    @(posedge clk); #1;
    check("uo_out", uo_out, m_uo);
    check("locked", {7'd0, locked}, {7'd0, m_locked});
    check("frame_count", frame_count, 8'(m_frames % 256));
    if (vf) lock_hist.push_back(locked);
  endtask

  // pix_mode: 0 random, 1 all lit, 2 one-cycle pulse on the last cycle of each line
  task automatic run_frame(input int n_lines, input int bad_line, input int bad_len, input int pix_mode);
    int len;
    bit pix;
    for (int l = 0; l < n_lines; l++) begin
      len = (l == bad_line) ? bad_len : int'(H_T);
      for (int c = 0; c < len; c++) begin
        case (pix_mode)
          0:       pix = 1'($urandom_range(0, 1));
          1:       pix = 1'b1;
          default: pix = (c == len - 1);
        endcase
        step(!(c < 2), !(l < 2), pix);
        if (pix_mode == 2 && l >= 3 && c == 0)       check("pulse_align", uo_out, 8'h19);
        if (pix_mode == 2 && l >= 3 && c == len - 1) check("pulse_quiet", uo_out, 8'h88);
        if (bad_line >= 0 && l == bad_line + 1 && c == 0)
          check("unlock_short_line", {7'd0, locked}, 8'd0);
      end
    end
  endtask

  task automatic do_reset();
    hsync_in = 1; vsync_in = 1; pixel_in = 0;
    rst = 1'b1;
    #2;
    check("rst_uo", uo_out, 8'h88);
    check("rst_locked", {7'd0, locked}, 8'd0);
    check("rst_fc", frame_count, 8'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b1, 8'h88, 1'b0, 8'd0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h08, 1'b0, 8'd0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 8'h80, 1'b0, 8'd1};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'd1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 8'h88, 1'b0, 8'd1};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 8'h80, 1'b0, 8'd2};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 8'h88, 1'b0, 8'd2};

    rst = 1'b1; hsync_in = 1; vsync_in = 1; pixel_in = 0;
    repeat (2) @(posedge clk);
    #1;
    check("init_uo", uo_out, 8'h88);
    check("init_locked", {7'd0, locked}, 8'd0);
    check("init_fc", frame_count, 8'd0);
    rst = 1'b0;

    // Unlocked pass-through and vsync-fall counting
    for (int i = 0; i < 7; i++) begin
      hsync_in = vecs[i].hs; vsync_in = vecs[i].vs; pixel_in = vecs[i].pix;
      @(posedge clk); #1;
      check("vec_uo", uo_out, vecs[i].uo);
      check("vec_locked", {7'd0, locked}, {7'd0, vecs[i].lk});
      check("vec_fc", frame_count, vecs[i].fc);
    end

    // Golden timing: lock after the third vsync fall
    do_reset();
    repeat (3) run_frame(V_T, -1, 0, 1);
    check("lock_vf1", {7'd0, lock_hist[0]}, 8'd0);
    check("lock_vf2", {7'd0, lock_hist[1]}, 8'd0);
    check("lock_vf3", {7'd0, lock_hist[2]}, 8'd1);

    // Pixel pulse one clock ahead of an hsync fall lands with it
    run_frame(V_T, -1, 0, 2);

    // Short line drops lock; two further frames relock
    run_frame(V_T, 3, H_T - 1, 0);
    repeat (2) run_frame(V_T, -1, 0, 0);
    check("relock_vf6", {7'd0, lock_hist[5]}, 8'd0);
    check("relock_vf7", {7'd0, lock_hist[6]}, 8'd1);

    // Frame one line short drops lock at its closing vsync fall
    run_frame(V_T - 1, -1, 0, 0);
    repeat (3) run_frame(V_T, -1, 0, 0);
    check("short_frame_vf9", {7'd0, lock_hist[8]}, 8'd0);
    check("short_frame_vf11", {7'd0, lock_hist[10]}, 8'd1);

    // Long run: foreground steps every 64 frames, wraps 7->1, frame_count wraps
    while (m_frames < 450) run_frame(V_T, -1, 0, 0);
    check("fc_after_450", frame_count, 8'd194);

    // Reset mid-frame, then hold for the cycle after release and relock
    for (int i = 0; i < 25; i++)
      step(!((i % H_T) < 2), !((i / H_T) < 2), 1'($urandom_range(0, 1)));
    do_reset();
    step(1'b1, 1'b1, 1'b1);
    check("post_rst_uo", uo_out, 8'h88);
    check("post_rst_locked", {7'd0, locked}, 8'd0);
    check("post_rst_fc", frame_count, 8'd0);
    repeat (3) run_frame(V_T, -1, 0, 1);
    check("post_rst_lock", {7'd0, lock_hist[2]}, 8'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
